hazard_forward_unit: RTL and testbench

Hazard detection and operand-forwarding controller for the 5-stage pipelined MIPS core. It reads the instruction held in the IF/ID register and keeps its own shadow pipeline of EX and MEM destination records. From these it drives the datapath's ID-stage forwarding mux selects. On a load-use dependence it stalls IF/ID for one cycle and injects a bubble into ID/EX.

---
 rtl/hazard_forward_unit.sv | 134 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Load-use stall and ID-stage operand forwarding control for the 5-stage MIPS pipeline.
// Optional stall-cycle counter port enabled by defining FWD_STALL_COUNT_EN.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        flush,
  output logic        ex_forward_a,
  output logic        ex_forward_b,
  output logic        mem_forward_a,
  output logic        mem_forward_b,
  output logic        stall,
  output logic        bubble
`ifdef FWD_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwr;
    logic       is_load;
  } rec_t;

  rec_t ex_rec;
  rec_t mem_rec;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       reads_rs;
  logic       reads_rt;
  logic       writes;
  logic       loads;
  logic [4:0] wdest;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];

  // Shift-amount bits and the MEM load flag are never consulted.
  logic unused_bits;
  assign unused_bits = ^{id_instr[10:6], mem_rec.is_load};

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    loads    = 1'b0;
    wdest    = 5'd0;
    case (op)
      6'h00: begin
        reads_rs = 1'b1;
        if (funct != 6'h08) begin
          reads_rt = 1'b1;
          writes   = 1'b1;
          wdest    = rd;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        wdest    = rt;
      end
      6'h23: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        loads    = 1'b1;
        wdest    = rt;
      end
      6'h2B, 6'h04, 6'h05: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  logic ex_can_fwd;
  logic mem_can_fwd;
  logic rs_hit_ex;
  logic rt_hit_ex;
  logic rs_hit_mem;
  logic rt_hit_mem;
  logic load_hazard;
  logic quiet;

  assign ex_can_fwd  = ex_rec.valid && ex_rec.regwr && (ex_rec.dest != 5'd0);
  assign mem_can_fwd = mem_rec.valid && mem_rec.regwr && (mem_rec.dest != 5'd0);
  assign rs_hit_ex   = reads_rs && ex_can_fwd && (ex_rec.dest == rs);
  assign rt_hit_ex   = reads_rt && ex_can_fwd && (ex_rec.dest == rt);
  assign rs_hit_mem  = reads_rs && mem_can_fwd && (mem_rec.dest == rs);
  assign rt_hit_mem  = reads_rt && mem_can_fwd && (mem_rec.dest == rt);
  assign load_hazard = ex_rec.is_load && (rs_hit_ex || rt_hit_ex);

  // A squashed ID instruction never stalls; reset silences everything.
  assign quiet = rst || flush || load_hazard;

  assign stall         = !rst && !flush && load_hazard;
  assign bubble        = stall;
  assign ex_forward_a  = !quiet && rs_hit_ex && !ex_rec.is_load;
  assign ex_forward_b  = !quiet && rt_hit_ex && !ex_rec.is_load;
  assign mem_forward_a = !quiet && rs_hit_mem;
  assign mem_forward_b = !quiet && rt_hit_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rec  <= '0;
      mem_rec <= '0;
    end else begin
      mem_rec         <= ex_rec;
      ex_rec.valid    <= !stall && !flush;
      ex_rec.dest     <= wdest;
      ex_rec.regwr    <= writes;
      ex_rec.is_load  <= loads;
    end
  end

`ifdef FWD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 32'd0;
    else if (stall)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: instruction-level reference model plus literal spot checks.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr = 32'd0;
  logic        flush = 1'b0;
  logic        ex_forward_a;
  logic        ex_forward_b;
  logic        mem_forward_a;
  logic        mem_forward_b;
  logic        stall;
  logic        bubble;
`ifdef FWD_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  hazard_forward_unit dut (
    .clk(clk),
    .rst(rst),
    .id_instr(id_instr),
    .flush(flush),
    .ex_forward_a(ex_forward_a),
    .ex_forward_b(ex_forward_b),
    .mem_forward_a(mem_forward_a),
    .mem_forward_b(mem_forward_b),
    .stall(stall),
    .bubble(bubble)
`ifdef FWD_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the instruction words sitting in EX and MEM.
  logic [31:0] m_ex_word  = 32'd0;
  logic [31:0] m_mem_word = 32'd0;
  bit          m_ex_v     = 1'b0;
  bit          m_mem_v    = 1'b0;
  logic [31:0] m_count    = 32'd0;

  function automatic bit f_reads_rs(input logic [31:0] w);
    logic [5:0] o;
    o = w[31:26];
    return o inside {6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05};
  endfunction

  function automatic bit f_reads_rt(input logic [31:0] w);
    logic [5:0] o;
    o = w[31:26];
    if (o == 6'h00) return w[5:0] != 6'h08;
    return o inside {6'h2B, 6'h04, 6'h05};
  endfunction

  // Destination register, with 0 meaning "nothing useful to forward".
  function automatic logic [4:0] f_dest(input logic [31:0] w);
    logic [5:0] o;
    o = w[31:26];
    if (o == 6'h00) return (w[5:0] == 6'h08) ? 5'd0 : w[15:11];
    if (o inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23}) return w[20:16];
    return 5'd0;
  endfunction

  function automatic bit f_uses(input logic [31:0] w, input logic [4:0] r, input bit rt_side);
    if (r == 5'd0) return 1'b0;
    if (rt_side) return f_reads_rt(w) && (w[20:16] == r);
    return f_reads_rs(w) && (w[25:21] == r);
  endfunction

  function automatic logic [5:0] model_outputs();
    logic [4:0] exd;
    logic [4:0] memd;
    bit         exld;
    bit         st;
    bit         q;
    exd  = m_ex_v ? f_dest(m_ex_word) : 5'd0;
    memd = m_mem_v ? f_dest(m_mem_word) : 5'd0;
    exld = m_ex_v && (m_ex_word[31:26] == 6'h23);
    st   = !rst && !flush && exld &&
           (f_uses(id_instr, exd, 1'b0) || f_uses(id_instr, exd, 1'b1));
    q    = rst || flush || st;
    return {!q && !exld && f_uses(id_instr, exd, 1'b0),
            !q && !exld && f_uses(id_instr, exd, 1'b1),
            !q && f_uses(id_instr, memd, 1'b0),
            !q && f_uses(id_instr, memd, 1'b1),
            st, st};
  endfunction

  always @(posedge clk) begin
    logic [5:0] e;
    e = model_outputs();
    if (rst) begin
      m_ex_v  <= 1'b0;
      m_mem_v <= 1'b0;
      m_count <= 32'd0;
    end else begin
      m_mem_word <= m_ex_word;
      m_mem_v    <= m_ex_v;
      m_ex_word  <= id_instr;
      m_ex_v     <= !e[1] && !flush;
      if (e[1]) m_count <= m_count + 32'd1;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] a;
    if (run) begin
      e = model_outputs();
      a = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL model t=%0t instr=%h got=%b expected=%b", $time, id_instr, a, e);
      end
`ifdef FWD_STALL_COUNT_EN
      checks++;
      if (stall_count !== m_count) begin
        failures++;
        $display("[TB] FAIL stall_count t=%0t got=%0d expected=%0d", $time, stall_count, m_count);
      end
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] w, input logic f);
    @(posedge clk);
    #1;
    rst      = r;
    id_instr = w;
    flush    = f;
  endtask

  // Literal expectation order: {exA, exB, memA, memB, stall, bubble}.
  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] a;
    @(negedge clk);
    #1;
    a = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble};
    checks++;
    if (a !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b", name, a, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 32'h8C22_0000, 1'b0);
    run = 1'b1;
    checkOutput("reset_quiet", 6'b000000);
    applyStimulus(1'b1, 32'h0063_2020, 1'b0);
    checkOutput("reset_quiet2", 6'b000000);

    applyStimulus(1'b0, 32'h0022_1820, 1'b0);
    checkOutput("ex_fwd_c1", 6'b000000);
    applyStimulus(1'b0, 32'h0063_2020, 1'b0);
    checkOutput("ex_fwd_c2", 6'b110000);

    applyStimulus(1'b0, 32'h0022_1820, 1'b0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0);
    applyStimulus(1'b0, 32'h0060_2822, 1'b0);
    checkOutput("mem_fwd", 6'b001000);

    applyStimulus(1'b0, 32'h8C22_0000, 1'b0);
    checkOutput("lw_issue", 6'b000000);
    applyStimulus(1'b0, 32'h0042_2020, 1'b0);
    checkOutput("load_use_stall", 6'b000011);
    applyStimulus(1'b0, 32'h0042_2020, 1'b0);
    checkOutput("load_use_after", 6'b001100);
`ifdef FWD_STALL_COUNT_EN
    checks++;
    if (stall_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL stall_count_literal got=%0d expected=1", stall_count);
    end
`endif

    applyStimulus(1'b0, 32'h2000_0005, 1'b0);
    checkOutput("zero_addi", 6'b000000);
    applyStimulus(1'b0, 32'h0000_0820, 1'b0);
    checkOutput("zero_add", 6'b000000);

    applyStimulus(1'b0, 32'h0022_1820, 1'b0);
    checkOutput("prio_c1", 6'b100000);
    applyStimulus(1'b0, 32'h0022_1820, 1'b0);
    checkOutput("prio_c2", 6'b001000);
    applyStimulus(1'b0, 32'h0060_3020, 1'b0);
    checkOutput("prio_both", 6'b101000);

    applyStimulus(1'b0, 32'h8C22_0000, 1'b0);
    applyStimulus(1'b0, 32'h0042_2020, 1'b1);
    checkOutput("flush_no_stall", 6'b000000);
    applyStimulus(1'b0, 32'h0084_2820, 1'b0);
    checkOutput("flush_bubble", 6'b000000);

    applyStimulus(1'b0, 32'h0022_3820, 1'b0);
    applyStimulus(1'b0, 32'hAC27_0000, 1'b0);
    checkOutput("sw_rt_ex", 6'b010000);
    applyStimulus(1'b0, 32'h00E0_0008, 1'b0);
    checkOutput("jr_rs_mem", 6'b001000);
    applyStimulus(1'b0, 32'h8C28_0000, 1'b0);
    applyStimulus(1'b0, 32'hAD28_0004, 1'b0);
    checkOutput("sw_rt_stall", 6'b000011);
    applyStimulus(1'b0, 32'hAD28_0004, 1'b0);
    checkOutput("sw_rt_mem", 6'b000100);

    applyStimulus(1'b0, 32'h8C22_0000, 1'b0);
    applyStimulus(1'b0, 32'h3C42_0001, 1'b0);
    checkOutput("lui_no_read", 6'b000000);

    applyStimulus(1'b0, 32'h8C22_0000, 1'b0);
    applyStimulus(1'b0, 32'h0042_2020, 1'b0);
    checkOutput("pre_reset_stall", 6'b000011);
    applyStimulus(1'b1, 32'h0042_2020, 1'b0);
    checkOutput("reset_mid_stall", 6'b000000);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0);
    checkOutput("post_reset_1", 6'b000000);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0);
    checkOutput("post_reset_2", 6'b000000);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0);
    @(posedge clk);
    #1;
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
